// File: rtl/disp_pkg.sv
// ============================================================================
// disp_pkg : segment table, anode encodings and helpers shared by both ends
// Rev 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int NUM_DIGITS = 4;

  // Lit patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Active-low anode selects
  localparam logic [3:0] AN_DIG_0 = 4'b1110;
  localparam logic [3:0] AN_DIG_1 = 4'b1101;
  localparam logic [3:0] AN_DIG_2 = 4'b1011;
  localparam logic [3:0] AN_DIG_3 = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } seg_dec_t;

  function automatic logic [2:0] count_low(input logic [3:0] an);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_decoder_seg7_to_hex.sv
// ============================================================================
// seg7_to_hex : lit 7-segment pattern to {legal, nibble}
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_to_hex
  import disp_pkg::*;
(
  input  logic [6:0] lit,
  output seg_dec_t   dec
);

  always_comb begin
    dec.legal  = 1'b1;
    dec.nibble = 4'h0;
    case (lit)
      SEG_HEX_0: dec.nibble = 4'h0;
      SEG_HEX_1: dec.nibble = 4'h1;
      SEG_HEX_2: dec.nibble = 4'h2;
      SEG_HEX_3: dec.nibble = 4'h3;
      SEG_HEX_4: dec.nibble = 4'h4;
      SEG_HEX_5: dec.nibble = 4'h5;
      SEG_HEX_6: dec.nibble = 4'h6;
      SEG_HEX_7: dec.nibble = 4'h7;
      SEG_HEX_8: dec.nibble = 4'h8;
      SEG_HEX_9: dec.nibble = 4'h9;
      SEG_HEX_A: dec.nibble = 4'hA;
      SEG_HEX_B: dec.nibble = 4'hB;
      SEG_HEX_C: dec.nibble = 4'hC;
      SEG_HEX_D: dec.nibble = 4'hD;
      SEG_HEX_E: dec.nibble = 4'hE;
      SEG_HEX_F: dec.nibble = 4'hF;
      default:   dec.legal  = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_decoder.sv
// ============================================================================
// display_scan_decoder : rebuilds a 16-bit hex value from scanned 7-seg lines
// Optional macro DISP_DEC_SYNC_EN adds a 2-flop input synchronizer.
// Rev 1.0
// ============================================================================
`default_nettype none

module display_scan_decoder
  import disp_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] num_out,
  output logic        num_valid,
  output logic        err_pulse,
  output logic        frame_err
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  logic [10:0] raw_in;

`ifdef DISP_DEC_SYNC_EN
  logic [10:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {an_in, seg_in};
      sync2_q <= sync1_q;
    end
  end

  assign raw_in = sync2_q;
`else
  assign raw_in = {an_in, seg_in};
`endif

  logic [10:0] in_q, in_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic [15:0] num_out_q, num_out_d;
  logic        num_valid_q, num_valid_d;
  logic        err_pulse_q, err_pulse_d;
  logic        frame_err_q, frame_err_d;

  logic [3:0]  an_cur;
  logic [6:0]  lit_cur;
  seg_dec_t    dec;
  logic        capture;
  logic [3:0]  mask_nxt;

  // Capture only fires when raw_in equals in_q, so decoding in_q is equivalent
  assign an_cur  = in_q[10:7];
  assign lit_cur = SEG_ACTIVE_LOW ? ~in_q[6:0] : in_q[6:0];

  seg7_to_hex u_seg7_to_hex (
    .lit (lit_cur),
    .dec (dec)
  );

  always_comb begin
    in_d        = raw_in;
    cnt_d       = cnt_q;
    done_d      = done_q;
    mask_d      = mask_q;
    shadow_d    = shadow_q;
    pending_d   = 1'b0;
    num_out_d   = num_out_q;
    num_valid_d = 1'b0;
    err_pulse_d = 1'b0;
    frame_err_d = frame_err_q;
    capture     = 1'b0;
    mask_nxt    = mask_q;

    if (raw_in != in_q) begin
      cnt_d  = 8'd0;
      done_d = 1'b0;
    end else begin
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + 8'd1;
      if (cnt_q == CNT_LAST && !done_q) begin
        capture = 1'b1;
        done_d  = 1'b1;
      end
    end

    // Frame completed on the previous edge: publish and start a new frame
    if (pending_q) begin
      num_out_d   = shadow_q;
      num_valid_d = 1'b1;
      frame_err_d = 1'b0;
      mask_d      = 4'h0;
    end

    if (capture && an_cur != AN_BLANK) begin
      if (count_low(an_cur) == 3'd1 && dec.legal) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (!an_cur[i]) begin
            shadow_d[4*i +: 4] = dec.nibble;
            mask_nxt[i]        = 1'b1;
          end
        end
        mask_d    = mask_nxt;
        pending_d = (mask_nxt == 4'hF);
      end else begin
        err_pulse_d = 1'b1;
        frame_err_d = 1'b1;
        mask_d      = 4'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q        <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      mask_q      <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      num_out_q   <= '0;
      num_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      in_q        <= in_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      mask_q      <= mask_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      num_out_q   <= num_out_d;
      num_valid_q <= num_valid_d;
      err_pulse_q <= err_pulse_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign num_out   = num_out_q;
  assign num_valid = num_valid_q;
  assign err_pulse = err_pulse_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_decoder.sv
// ============================================================================
// tb_display_scan_decoder : directed + random stimulus against a dwell model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_decoder;

  localparam int SETTLE = 4;
  localparam bit SAL    = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] num_out;
  logic        num_valid;
  logic        err_pulse;
  logic        frame_err;

  always #5 clk = ~clk;

  display_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .SEG_ACTIVE_LOW (SAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .an_in     (an_in),
    .num_out   (num_out),
    .num_valid (num_valid),
    .err_pulse (err_pulse),
    .frame_err (frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int lookup(input logic [6:0] lit);
    for (int k = 0; k < 16; k++) if (tbl[k] == lit) return k;
    return -1;
  endfunction

  // Reference model: a digit is sampled once when its input value has been
  // present for SETTLE+1 consecutive edges (reset behaves as input 0 seen once).
  logic [10:0] m_prev, m_cur, m_s1, m_s2;
  int          m_hold;
  logic [3:0]  m_mask, m_an;
  logic [6:0]  m_lit;
  logic [3:0]  m_dig [4];
  bit          m_pend;
  logic [15:0] e_num;
  bit          e_valid, e_err, e_ferr;
  bit          model_live = 1'b0;
  int          m_zeros, m_k;

  always @(posedge clk) begin
    if (rst) begin
      m_prev = '0; m_hold = 1; m_mask = '0; m_pend = 1'b0;
      m_s1 = '0; m_s2 = '0;
      for (int d = 0; d < 4; d++) m_dig[d] = 4'h0;
      e_num = '0; e_valid = 1'b0; e_err = 1'b0; e_ferr = 1'b0;
      model_live = 1'b1;
    end else begin
`ifdef DISP_DEC_SYNC_EN
      m_cur = m_s2;
      m_s2  = m_s1;
      m_s1  = {an_in, seg_in};
`else
      m_cur = {an_in, seg_in};
`endif
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (m_pend) begin
        e_num   = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        e_valid = 1'b1;
        e_ferr  = 1'b0;
        m_pend  = 1'b0;
        m_mask  = 4'h0;
      end
      if (m_cur != m_prev) m_hold = 1;
      else if (m_hold < 1000) m_hold++;
      if (m_hold == SETTLE + 1) begin
        m_an    = m_cur[10:7];
        m_lit   = SAL ? ~m_cur[6:0] : m_cur[6:0];
        m_zeros = 4 - $countones(m_an);
        m_k     = lookup(m_lit);
        if (m_an == 4'hF) begin
          m_zeros = 0;
        end else if (m_zeros == 1 && m_k >= 0) begin
          for (int d = 0; d < 4; d++) begin
            if (!m_an[d]) begin
              m_dig[d]  = m_k[3:0];
              m_mask[d] = 1'b1;
            end
          end
          if (m_mask == 4'hF) m_pend = 1'b1;
        end else begin
          e_err  = 1'b1;
          e_ferr = 1'b1;
          m_mask = 4'h0;
        end
      end
      m_prev = m_cur;
    end
  end

  int valid_seen = 0;
  int err_seen   = 0;

  always @(negedge clk) begin
    if (model_live) begin
      check("num_out",   {16'h0, num_out},   {16'h0, e_num});
      check("num_valid", {31'h0, num_valid}, {31'h0, e_valid});
      check("err_pulse", {31'h0, err_pulse}, {31'h0, e_err});
      check("frame_err", {31'h0, frame_err}, {31'h0, e_ferr});
      if (!rst && num_valid) valid_seen++;
      if (!rst && err_pulse) err_seen++;
    end
  end

  task automatic show(input int d, input logic [3:0] v, input int n);
    logic [3:0] one;
    one    = 4'b0001;
    an_in  = ~(one << d);
    seg_in = SAL ? ~tbl[v] : tbl[v];
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] lit, input int n);
    an_in  = an;
    seg_in = SAL ? ~lit : lit;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h00, n);
  endtask

  int v0, e0;
  int r;

  initial begin
    rst    = 1'b1;
    an_in  = 4'hF;
    seg_in = 7'h7F;
    @(posedge clk);
    #1;
    // Reset held for two cycles with a digit on the lines
    show(0, 4'h4, 2);
    check("t1_num_out",   {16'h0, num_out},   32'h0);
    check("t1_num_valid", {31'h0, num_valid}, 32'h0);
    check("t1_frame_err", {31'h0, frame_err}, 32'h0);
    rst = 1'b0;

    v0 = valid_seen;
    show(0, 4'h4, 5); show(1, 4'h3, 5); show(2, 4'h2, 5); show(3, 4'h1, 5);
    idle(4);
    check("t2_num_out", {16'h0, num_out}, 32'h1234);
    check("t2_pulses",  valid_seen - v0,  1);

    v0 = valid_seen;
    show(0, 4'h4, 5); show(1, 4'h3, 5); show(2, 4'h2, 4); show(3, 4'h1, 5);
    idle(4);
    check("t3_short_pulses", valid_seen - v0, 0);
    show(2, 4'h2, 5);
    idle(4);
    check("t3_num_out", {16'h0, num_out}, 32'h1234);
    check("t3_pulses",  valid_seen - v0,  1);

    e0 = err_seen;
    show(0, 4'h5, 5);
    drive(4'b1101, 7'h01, 5);
    idle(2);
    check("t4_err_pulses", err_seen - e0, 1);
    check("t4_frame_err",  {31'h0, frame_err}, 32'h1);
    show(0, 4'hA, 5); show(1, 4'hB, 5); show(2, 4'hC, 5); show(3, 4'hD, 5);
    idle(4);
    check("t4_num_out",       {16'h0, num_out},   32'hDCBA);
    check("t4_frame_err_clr", {31'h0, frame_err}, 32'h0);

    e0 = err_seen;
    v0 = valid_seen;
    drive(4'b1100, 7'h06, 10);
    idle(10);
    check("t5_err_pulses",   err_seen - e0,   1);
    check("t5_valid_pulses", valid_seen - v0, 0);

    show(0, 4'h5, 5); show(0, 4'h9, 5);
    show(1, 4'h0, 5); show(2, 4'h0, 5); show(3, 4'h0, 5);
    idle(4);
    check("t6_num_out", {16'h0, num_out}, 32'h0009);

    show(0, 4'h7, 5); show(1, 4'h7, 5);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_num_out", {16'h0, num_out}, 32'h0);
    v0 = valid_seen;
    show(2, 4'h3, 5); show(3, 4'h3, 5);
    idle(4);
    check("t6_partial_pulses", valid_seen - v0, 0);
    show(0, 4'h1, 5); show(1, 4'h2, 5);
    idle(4);
    check("t6_post_rst_num", {16'h0, num_out}, 32'h3321);

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
        rst = 1'b0;
      end else if (r < 10) begin
        drive(4'($urandom), 7'($urandom), $urandom_range(1, 8));
      end else if (r < 15) begin
        idle($urandom_range(1, 8));
      end else begin
        show($urandom_range(0, 3), 4'($urandom), $urandom_range(3, 8));
      end
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_scan_decoder.md
Name: display_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit display driver.
- Observes time-multiplexed 7-segment lines (segments plus active-low digit anodes) and rebuilds the 16-bit hex value being shown.
- Delivers the value with a one-cycle valid strobe once all four digits are captured.
- Used for board-level loopback checks and for reading displayed values back into the DDS control path.

Parameters:
- SETTLE_CYCLES, 4, consecutive cycles the {an_in, seg_in} pair must stay unchanged before a digit is sampled; legal range 1..255.
- SEG_ACTIVE_LOW, 1, 1 = a lit segment reads 0 on seg_in; 0 = lit segment reads 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  7  segment lines {g,f,e,d,c,b,a}.
- an_in  input  4  active-low digit select; an_in[i]=0 selects digit i.
- num_out  output  16  last complete frame; digit i occupies num_out[4i+3:4i].
- num_valid  output  1  one-cycle pulse when num_out updates.
- err_pulse  output  1  one-cycle pulse on an illegal pattern or illegal anode combination.
- frame_err  output  1  sticky; set with err_pulse, cleared on the next num_valid or on rst.

Behaviour:
- Reset: num_out=16'h0000, num_valid=0, err_pulse=0, frame_err=0. Internal input copy, stable counter, capture mask, shadow register and done flag all go to 0.
- Input stage: in_q registers {an_in, seg_in} every cycle.
- Stability tracking:
  - If the current input differs from in_q, stable_cnt<=0 and done<=0.
  - Otherwise stable_cnt increments, saturating at SETTLE_CYCLES-1.
- Capture event: input equals in_q, stable_cnt==SETTLE_CYCLES-1 and done==0. The event sets done=1, so there is exactly one capture per dwell.
- Capture timing: a digit must be held for at least SETTLE_CYCLES+1 cycles. With SETTLE_CYCLES=4, an input applied in cycle 0 is captured at the end of cycle 4.
- Segment normalisation: when SEG_ACTIVE_LOW=1, seg_in is inverted before decode.
- Decode table (lit pattern, hex gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Anode classification at a capture event:
  - an_in==4'hF (blank): no capture, no error.
  - Exactly one bit low, pattern legal: shadow nibble i <= decoded value, mask[i]<=1. A recapture of the same digit overwrites the nibble (latest wins).
  - Exactly one bit low, pattern not in table: err_pulse=1 next cycle, frame_err<=1, mask<=0 (the frame is discarded).
  - More than one bit low: handled as an illegal pattern (error, mask cleared).
- Frame completion:
  - When a capture makes mask==4'hF, on the next edge num_out<=shadow (including the completing nibble), num_valid=1 for one cycle, mask<=0 and frame_err<=0.
  - Digit order does not matter.
- Simultaneous events: a capture that both completes the frame and errors is impossible, because an erroring capture never sets a mask bit.
- Reset mid-frame: all partial mask and shadow state is dropped, and the first post-reset frame needs all four digits.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro DISP_DEC_SYNC_EN.
- When defined: seg_in and an_in pass through a 2-flop synchronizer before in_q, adding 2 cycles of latency. This is for inputs sourced from pins or an asynchronous clock domain.
- When undefined: inputs feed in_q directly, for same-clock loopback use.
- Decode, settle and frame behaviour are otherwise identical.

Decomposition:
- Shared package/include disp_pkg:
  - NUM_DIGITS=4.
  - The 16 segment-pattern constants (SEG_HEX_0..SEG_HEX_F), shared with the display driver so both ends use one table.
  - Anode one-hot constants.
- One combinational sub-module, seg7_to_hex: takes a 7-bit lit pattern and returns {legal, nibble[3:0]}.
- All sequencing stays in display_scan_decoder.

Test Plan:
1. Reset: assert rst for 2 cycles while digits are driven → num_out=0000, num_valid=0, frame_err=0.
2. Digits 0..3 driven (SEG_ACTIVE_LOW=1) with patterns for 4,3,2,1, each held 5 cycles (SETTLE_CYCLES=4) → num_out=16'h1234. num_valid pulses exactly once, 1 cycle after digit 3's capture edge.
3. Same frame with digit 2 held only 4 cycles → no capture of digit 2, no num_valid. Re-driving digit 2 for 5 cycles then produces num_valid with 16'h1234.
4. Digit 1 shows illegal pattern 7'h01 (lit) → err_pulse for one cycle, frame_err=1, mask cleared. The next full frame of A,B,C,D on digits 0..3 gives 16'hDCBA and clears frame_err.
5. an_in=4'b1100 held 10 cycles → err_pulse. an_in=4'hF held 10 cycles → no error, no capture.
6. Digit 0 captured as 5 then recaptured as 9 within one frame, plus digits 1..3 = 0 → num_out=16'h0009. rst asserted after two captures → the next frame requires all four digits.
